// File: rtl/pb_ctl_pkg.sv
// Shared constants, state codes and event payload for the push-button front end.
package pb_ctl_pkg;

    localparam int unsigned PB_DB_DEPTH     = 4;
    localparam int unsigned PB_HCNT_W       = 8;
    localparam int unsigned PB_LONG_TICKS   = 153;
    localparam int unsigned PB_REPEAT_TICKS = 31;

    localparam logic [1:0] PB_IDLE    = 2'b00;
    localparam logic [1:0] PB_PRESSED = 2'b01;
    localparam logic [1:0] PB_HELD    = 2'b10;

    typedef struct packed {
        logic press;
        logic lng;
        logic rpt;
        logic rls;
    } pb_evt_t;

endpackage

// File: rtl/pb_debounce.sv
// Key synchroniser plus tick-sampled shift-register debouncer; tick is the
// registered debounce strobe aligned with the pb_debounced update it caused.
module pb_debounce #(
    parameter int unsigned DB_DEPTH = 4
) (
    input  logic clk_40M,
    input  logic rst_n,
    input  logic clk_debounce,
    input  logic pb_in,
    output logic pb_debounced,
    output logic tick
);

    logic                pb_m;
    logic                pb_s;
    logic                clk_debounce_d;
    logic                tick_c;
    logic [DB_DEPTH-1:0] shift_q;
    logic [DB_DEPTH-1:0] shift_next;

    assign tick_c     = clk_debounce & ~clk_debounce_d;
    assign shift_next = {shift_q[DB_DEPTH-2:0], pb_s};

    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            pb_m           <= 1'b0;
            pb_s           <= 1'b0;
            clk_debounce_d <= 1'b0;
            tick           <= 1'b0;
            shift_q        <= '0;
            pb_debounced   <= 1'b0;
        end else begin
            pb_m           <= pb_in;
            pb_s           <= pb_m;
            clk_debounce_d <= clk_debounce;
            tick           <= tick_c;
            // Level only moves once DB_DEPTH consecutive samples agree
            if (tick_c) begin
                shift_q <= shift_next;
                if (&shift_next) begin
                    pb_debounced <= 1'b1;
                end else if (~|shift_next) begin
                    pb_debounced <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pb_ctl.sv
// Push-button controller: debounced key into press / long / repeat / release
// one-cycle event pulses in the clk_40M domain.
module pb_ctl
    import pb_ctl_pkg::*;
#(
    parameter int unsigned DB_DEPTH     = PB_DB_DEPTH,
    parameter int unsigned HCNT_W       = PB_HCNT_W,
    parameter int unsigned LONG_TICKS   = PB_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = PB_REPEAT_TICKS
) (
    input  logic clk_40M,
    input  logic rst_n,
    input  logic clk_debounce,
    input  logic pb_in,
    output logic pb_debounced,
    output logic pb_press,
    output logic pb_long,
    output logic pb_repeat,
    output logic pb_release
);

    logic              db_tick;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [HCNT_W-1:0] hold_cnt;
    logic [HCNT_W-1:0] hold_next;
    logic [HCNT_W-1:0] hold_inc;
    pb_evt_t           evt_q;
    pb_evt_t           evt_next;

    pb_debounce #(
        .DB_DEPTH     (DB_DEPTH)
    ) u_debounce (
        .clk_40M      (clk_40M),
        .rst_n        (rst_n),
        .clk_debounce (clk_debounce),
        .pb_in        (pb_in),
        .pb_debounced (pb_debounced),
        .tick         (db_tick)
    );

    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PB_IDLE;
            hold_cnt <= '0;
            evt_q    <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            evt_q    <= evt_next;
        end
    end

    // Release is tested first so it wins over a same-cycle threshold match
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        evt_next   = '0;
        hold_inc   = hold_cnt + HCNT_W'(1);
        case (state)
            PB_IDLE: begin
                if (pb_debounced) begin
                    state_next     = PB_PRESSED;
                    hold_next      = '0;
                    evt_next.press = 1'b1;
                end
            end
            PB_PRESSED: begin
                if (!pb_debounced) begin
                    state_next   = PB_IDLE;
                    evt_next.rls = 1'b1;
                end else if (db_tick) begin
                    if (hold_inc == HCNT_W'(LONG_TICKS)) begin
                        state_next   = PB_HELD;
                        hold_next    = '0;
                        evt_next.lng = 1'b1;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
            end
            PB_HELD: begin
                if (!pb_debounced) begin
                    state_next   = PB_IDLE;
                    evt_next.rls = 1'b1;
                end else if (db_tick) begin
                    if (hold_inc == HCNT_W'(REPEAT_TICKS)) begin
                        hold_next    = '0;
                        evt_next.rpt = 1'b1;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
            end
            default: state_next = PB_IDLE;
        endcase
    end

    assign pb_press   = evt_q.press;
    assign pb_long    = evt_q.lng;
    assign pb_repeat  = evt_q.rpt;
    assign pb_release = evt_q.rls;

endmodule

// File: tb/tb_pb_ctl.sv
// Directed bench for pb_ctl: expected events are queued with the tick they
// follow and matched against observed pulses, including their exact cycle.
module tb_pb_ctl;

    localparam int K_PRESS = 8;
    localparam int K_LONG  = 4;
    localparam int K_REP   = 2;
    localparam int K_REL   = 1;

    logic clk_40M = 1'b0;
    logic rst_n;
    logic clk_debounce;
    logic pb_in;
    logic pb_debounced;
    logic pb_press;
    logic pb_long;
    logic pb_repeat;
    logic pb_release;

    int cyc     = 0;
    int n_ticks = 0;
    int n_chk   = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int t0;
    int tick_edge [0:1023];

    typedef struct {
        int kind;
        int tk;
    } exp_t;
    exp_t sb[$];

    logic [3:0] prev_ev = 4'b0;
    wire  [3:0] ev = {pb_press, pb_long, pb_repeat, pb_release};

    pb_ctl #(
        .DB_DEPTH     (4),
        .HCNT_W       (8),
        .LONG_TICKS   (5),
        .REPEAT_TICKS (3)
    ) dut (
        .clk_40M      (clk_40M),
        .rst_n        (rst_n),
        .clk_debounce (clk_debounce),
        .pb_in        (pb_in),
        .pb_debounced (pb_debounced),
        .pb_press     (pb_press),
        .pb_long      (pb_long),
        .pb_repeat    (pb_repeat),
        .pb_release   (pb_release)
    );

    always #5 clk_40M = ~clk_40M;

    always @(posedge clk_40M) cyc <= cyc + 1;

    // Divided debounce clock, period 8 cycles; records the clk_40M edge at which each tick lands
    initial begin
        foreach (tick_edge[i]) tick_edge[i] = -1;
        clk_debounce = 1'b0;
        forever begin
            repeat (4) @(negedge clk_40M);
            clk_debounce = ~clk_debounce;
            if (clk_debounce) begin
                tick_edge[n_ticks + 1] = cyc + 1;
                n_ticks = n_ticks + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time=%0t required<200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic expect_ev(input int kind, input int tk);
        exp_t e;
        e.kind = kind;
        e.tk   = tk;
        sb.push_back(e);
    endtask

    // Return at the falling edge just after tick k has been applied to the DUT
    task automatic at_tick(input int k);
        while (n_ticks < k || cyc < tick_edge[k]) @(negedge clk_40M);
    endtask

    // Scoreboard: every pulse must be single, one cycle wide, and the next queued event
    always @(negedge clk_40M) begin
        exp_t e;
        if (ev != 4'b0) begin
            chk("onehot", $countones(ev), 1);
            chk("pulse_width", int'(ev & prev_ev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_event", int'(ev), 0);
            end else begin
                e = sb.pop_front();
                chk("event_kind", int'(ev), e.kind);
                chk("event_cycle", cyc, tick_edge[e.tk] + 1);
            end
        end
        prev_ev <= ev;
    end

    initial begin
        rst_n = 1'b0;
        pb_in = 1'b0;
        repeat (2) @(negedge clk_40M);
        chk("reset_outputs", int'({pb_debounced, ev}), 0);
        rst_n = 1'b1;

        // Clean press held 20 ticks: press, long, repeats every 3 ticks, release
        t0 = n_ticks + 1;
        at_tick(t0);
        pb_in = 1'b1;
        expect_ev(K_PRESS, t0 + 4);
        expect_ev(K_LONG,  t0 + 9);
        expect_ev(K_REP,   t0 + 12);
        expect_ev(K_REP,   t0 + 15);
        expect_ev(K_REP,   t0 + 18);
        expect_ev(K_REP,   t0 + 21);
        expect_ev(K_REL,   t0 + 24);
        at_tick(t0 + 3);
        chk("db_before_4th_tick", int'(pb_debounced), 0);
        at_tick(t0 + 4);
        chk("db_on_4th_tick", int'(pb_debounced), 1);
        at_tick(t0 + 20);
        pb_in = 1'b0;
        at_tick(t0 + 28);
        chk("t1_drained", sb.size(), 0);

        // Bounce 1,0,1,0,1 then stable low: level never changes, no events
        t0 = n_ticks + 1;
        for (int i = 0; i < 5; i++) begin
            at_tick(t0 + i);
            pb_in = (i % 2 == 0) ? 1'b1 : 1'b0;
        end
        at_tick(t0 + 5);
        pb_in = 1'b0;
        chk("bounce_db_a", int'(pb_debounced), 0);
        at_tick(t0 + 6);
        chk("bounce_db_b", int'(pb_debounced), 0);
        at_tick(t0 + 10);
        chk("bounce_db_c", int'(pb_debounced), 0);

        // Short press: three hold ticks, released before the long threshold
        t0 = n_ticks + 1;
        at_tick(t0);
        pb_in = 1'b1;
        expect_ev(K_PRESS, t0 + 4);
        expect_ev(K_REL,   t0 + 8);
        at_tick(t0 + 4);
        pb_in = 1'b0;
        at_tick(t0 + 12);
        chk("t3_drained", sb.size(), 0);

        // Level falls on the tick that would complete the long count: release only
        t0 = n_ticks + 1;
        at_tick(t0);
        pb_in = 1'b1;
        expect_ev(K_PRESS, t0 + 4);
        expect_ev(K_REL,   t0 + 9);
        at_tick(t0 + 5);
        pb_in = 1'b0;
        at_tick(t0 + 13);
        chk("t4_drained", sb.size(), 0);

        // Reset while in HELD with key still down, then a fresh press afterwards
        t0 = n_ticks + 1;
        at_tick(t0);
        pb_in = 1'b1;
        expect_ev(K_PRESS, t0 + 4);
        expect_ev(K_LONG,  t0 + 9);
        at_tick(t0 + 11);
        chk("held_db_high", int'(pb_debounced), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({pb_debounced, ev}), 0);
        chk("async_reset_state", int'(dut.state), 0);
        repeat (3) @(negedge clk_40M);
        rst_n = 1'b1;
        expect_ev(K_PRESS, t0 + 15);
        expect_ev(K_REL,   t0 + 19);
        at_tick(t0 + 14);
        chk("post_reset_db_low", int'(pb_debounced), 0);
        at_tick(t0 + 15);
        chk("post_reset_db_high", int'(pb_debounced), 1);
        pb_in = 1'b0;
        at_tick(t0 + 22);
        chk("t5_drained", sb.size(), 0);

        // Illegal state code recovers to IDLE without emitting a pulse
        @(negedge clk_40M);
        force dut.state = 2'b11;
        @(posedge clk_40M);
        #1;
        release dut.state;
        repeat (2) @(negedge clk_40M);
        chk("illegal_state_recovers", int'(dut.state), 0);
        repeat (20) @(negedge clk_40M);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
